// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM
// states and the fixed iteration count.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam int MDU_ITER  = 32;
  localparam int MDU_CNT_W = $clog2(MDU_ITER);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: a right-shifting shift-add multiply step
// or a restoring divide step, selected by is_div.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mag,
  input  logic               bit_in,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_nx
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] rem_sh_s;
  logic [WIDTH:0] diff_s;
  logic           ge_s;

  // Multiply: add the multiplicand into the high half, then shift right.
  // Divide: acc = {rem, quot}; the dividend bit enters the remainder LSB.
  always_comb begin
    sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (bit_in ? {1'b0, mag} : {(WIDTH+1){1'b0}});
    rem_sh_s = {acc[2*WIDTH-1:WIDTH], bit_in};
    diff_s   = rem_sh_s - {1'b0, mag};
    ge_s     = (rem_sh_s >= {1'b0, mag});
    if (is_div) begin
      if (ge_s) begin
        acc_nx = {diff_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = {rem_sh_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nx = {sum_s, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit: fixed 32-iteration MULT/MULTU/DIV/DIVU with
// start/busy/done handshake and a synchronous cancel for pipeline flushes.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Start,
  input  logic               Cancel,
  input  logic [1:0]         MDUOp,
  input  logic [WIDTH-1:0]   SrcA,
  input  logic [WIDTH-1:0]   SrcB,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] MDUResult
);

  localparam logic [MDU_CNT_W-1:0] CNT_LAST = MDU_CNT_W'(MDU_ITER - 1);
  localparam logic [MDU_CNT_W-1:0] CNT_ONE  = MDU_CNT_W'(1);

  mdu_state_t             state_r, state_nx;
  logic                   start_s, load_s;
  logic [MDU_CNT_W-1:0]   count_r;
  logic [2*WIDTH-1:0]     acc_r, acc_nx_s, fix_s;
  logic [WIDTH-1:0]       mag_r, opnd_r;
  logic                   is_div_r, neg_hi_r, neg_lo_r;
  logic                   signed_s, div_s, a_neg_s, b_neg_s, bit_in_s;
  logic [WIDTH-1:0]       a_mag_s, b_mag_s, hi_s, lo_s, hi_fix_s, lo_fix_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next state; Cancel overrides everything, including a pending Start.
  always_comb begin
    state_nx = state_r;
    start_s  = 1'b0;
    load_s   = 1'b0;
    if (Cancel) begin
      state_nx = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (Start) begin
            state_nx = ST_CALC;
            start_s  = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end
        ST_CALC: begin
          if (count_r == CNT_LAST) begin
            state_nx = ST_DONE;
            load_s   = 1'b1;
          end else begin
            state_nx = ST_CALC;
          end
        end
        ST_DONE: state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Operand magnitudes for the signed ops, taken when a request is accepted.
  always_comb begin
    signed_s = (MDUOp == MDU_MULT) || (MDUOp == MDU_DIV);
    div_s    = (MDUOp == MDU_DIV) || (MDUOp == MDU_DIVU);
    a_neg_s  = signed_s && SrcA[WIDTH-1];
    b_neg_s  = signed_s && SrcB[WIDTH-1];
    if (a_neg_s) begin
      a_mag_s = -SrcA;
    end else begin
      a_mag_s = SrcA;
    end
    if (b_neg_s) begin
      b_mag_s = -SrcB;
    end else begin
      b_mag_s = SrcB;
    end
  end

  // opnd_r streams multiplier bits LSB-first or dividend bits MSB-first.
  assign bit_in_s = is_div_r ? opnd_r[WIDTH-1] : opnd_r[0];

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc    (acc_r),
    .mag    (mag_r),
    .bit_in (bit_in_s),
    .is_div (is_div_r),
    .acc_nx (acc_nx_s)
  );

  // Sign fix applied to the final iteration's output.
  always_comb begin
    hi_s     = acc_nx_s[2*WIDTH-1:WIDTH];
    lo_s     = acc_nx_s[WIDTH-1:0];
    hi_fix_s = neg_hi_r ? -hi_s : hi_s;
    lo_fix_s = neg_lo_r ? -lo_s : lo_s;
    if (is_div_r) begin
      fix_s = {hi_fix_s, lo_fix_s};
    end else if (neg_lo_r) begin
      fix_s = -acc_nx_s;
    end else begin
      fix_s = acc_nx_s;
    end
  end

  // Datapath registers and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r   <= {MDU_CNT_W{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      mag_r     <= {WIDTH{1'b0}};
      opnd_r    <= {WIDTH{1'b0}};
      is_div_r  <= 1'b0;
      neg_hi_r  <= 1'b0;
      neg_lo_r  <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      MDUResult <= {(2*WIDTH){1'b0}};
    end else begin
      Busy <= (state_nx != ST_IDLE);
      Done <= (state_nx == ST_DONE);
      if (start_s) begin
        count_r  <= {MDU_CNT_W{1'b0}};
        acc_r    <= {(2*WIDTH){1'b0}};
        is_div_r <= div_s;
        if (div_s) begin
          mag_r    <= b_mag_s;
          opnd_r   <= a_mag_s;
          // Divide by zero keeps an all-ones quotient regardless of sign.
          neg_lo_r <= (a_neg_s ^ b_neg_s) && (SrcB != {WIDTH{1'b0}});
          neg_hi_r <= a_neg_s;
        end else begin
          mag_r    <= a_mag_s;
          opnd_r   <= b_mag_s;
          neg_lo_r <= a_neg_s ^ b_neg_s;
          neg_hi_r <= a_neg_s ^ b_neg_s;
        end
      end else if ((state_r == ST_CALC) && !Cancel) begin
        count_r <= count_r + CNT_ONE;
        acc_r   <= acc_nx_s;
        if (is_div_r) begin
          opnd_r <= {opnd_r[WIDTH-2:0], 1'b0};
        end else begin
          opnd_r <= {1'b0, opnd_r[WIDTH-1:1]};
        end
      end
      if (load_s) begin
        MDUResult <= fix_s;
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: cycle-level behavioural model (accept/latency
// timeline plus plain-arithmetic results), directed cases and random traffic.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start, Cancel;
  logic [1:0]  MDUOp;
  logic [31:0] SrcA, SrcB;
  logic        Busy, Done;
  logic [63:0] MDUResult;

  int          vectors = 0;
  int          miscompares = 0;
  int          m_left = 0;
  logic [63:0] m_result = 64'h0;
  logic [63:0] m_pend = 64'h0;
  bit          chk_en = 1'b0;

  mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Cancel(Cancel), .MDUOp(MDUOp),
    .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done), .MDUResult(MDUResult)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_f(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q = 0;
    r = 0;
    case (op)
      MDU_MULT:  res = sa * sb;
      MDU_MULTU: res = {32'h0, a} * {32'h0, b};
      MDU_DIV: begin
        if (b == 32'h0) begin
          res = {a, 32'hFFFFFFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      MDU_DIVU: begin
        if (b == 32'h0) res = {a, 32'hFFFFFFFF};
        else            res = {a % b, a / b};
      end
      default: res = 64'h0;
    endcase
    return res;
  endfunction

  // One clock: drive inputs after a falling edge, advance the model at the rising edge.
  task automatic tick(input logic s, input logic c, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    Start = s; Cancel = c; MDUOp = op; SrcA = a; SrcB = b;
    @(posedge clk);
    if (!rst) begin
      if (c) begin
        m_left = 0;
      end else if (m_left == 0) begin
        if (s) begin
          m_left = 33;
          m_pend = ref_f(op, a, b);
        end
      end else begin
        m_left--;
        if (m_left == 1) m_result = m_pend;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int lat;
    tick(1'b1, 1'b0, op, a, b);
    lat = 1;
    while (Done !== 1'b1 && lat < 40) begin
      tick(1'b0, 1'b0, op, a, b);
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'd33);
    check(name, MDUResult, exp);
    check({name, "_model"}, ref_f(op, a, b), exp);
    idle(1);
  endtask

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("busy", 64'(Busy), (m_left > 0) ? 64'd1 : 64'd0);
      check("done", 64'(Done), (m_left == 1) ? 64'd1 : 64'd0);
      check("result", MDUResult, m_result);
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          n;
    rst = 1'b1; Start = 1'b0; Cancel = 1'b0; MDUOp = 2'b00; SrcA = 32'h0; SrcB = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_result", MDUResult, 64'h0);
    #2 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    run_op("multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run_op("mult_neg",  MDU_MULT,  32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1);
    run_op("mult_min",  MDU_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000);
    run_op("div_neg",   MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD);
    run_op("divu",      MDU_DIVU,  32'h00000007, 32'h00000002, 64'h00000001_00000003);
    run_op("divu_zero", MDU_DIVU,  32'h00000064, 32'h00000000, 64'h00000064_FFFFFFFF);
    run_op("div_zero",  MDU_DIV,   32'hFFFFFFFB, 32'h00000000, 64'hFFFFFFFB_FFFFFFFF);
    run_op("div_ovf",   MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);

    // Second Start during CALC is dropped.
    tick(1'b1, 1'b0, MDU_MULTU, 32'd6, 32'd7);
    idle(4);
    tick(1'b1, 1'b0, MDU_MULTU, 32'd100, 32'd100);
    n = 0;
    while (m_left > 0 && n < 40) begin idle(1); n++; end
    check("restart_ignored", MDUResult, 64'd42);

    // Cancel mid-operation: no Done, result retained.
    tick(1'b1, 1'b0, MDU_DIVU, 32'd1000, 32'd7);
    idle(9);
    tick(1'b0, 1'b1, MDU_DIVU, 32'd0, 32'd0);
    check("cancel_busy", 64'(Busy), 64'd0);
    idle(40);
    check("cancel_keep", MDUResult, 64'd42);

    // Cancel together with Start in IDLE.
    tick(1'b1, 1'b1, MDU_MULT, 32'd3, 32'd3);
    check("cs_busy", 64'(Busy), 64'd0);
    idle(2);

    // Asynchronous reset during a DIV.
    tick(1'b1, 1'b0, MDU_DIV, 32'hFFFFFF9C, 32'd7);
    idle(19);
    #2 rst = 1'b1;
    m_left = 0;
    m_result = 64'h0;
    #1;
    check("arst_busy", 64'(Busy), 64'd0);
    check("arst_done", 64'(Done), 64'd0);
    check("arst_result", MDUResult, 64'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    run_op("divu_after_rst", MDU_DIVU, 32'd9, 32'd3, 64'h00000000_00000003);

    // Random traffic with stray Starts and occasional Cancels.
    for (int k = 0; k < 150; k++) begin
      op = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 4))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        default: b = 32'($urandom);
      endcase
      tick(1'b1, 1'b0, op, a, b);
      n = 0;
      while (m_left > 0 && n < 40) begin
        tick(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
             2'($urandom_range(0, 3)), 32'($urandom), 32'($urandom));
        n++;
      end
      idle(int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit for the MIPS core's execute stage. It sits directly upstream of the HI/LO register block and produces the 64-bit `MDUResult` that block writes into {Hi,Lo} when `HiloSrc`=0. It supports MULT, MULTU, DIV and DIVU with a start/busy/done handshake, a cancel input for pipeline flushes, and a fixed 32-iteration latency for every operation.

## Interface
Parameters:
- `WIDTH`, 32: operand width; result is 2*WIDTH.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `Start`  in  1  operation request; sampled only in IDLE.
- `Cancel`  in  1  synchronous abort (flush); returns to IDLE.
- `MDUOp`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `SrcA`  in  WIDTH  multiplicand / dividend.
- `SrcB`  in  WIDTH  multiplier / divisor.
- `Busy`  out  1  unit occupied (state != IDLE); the issue stage stalls on it.
- `Done`  out  1  one-cycle pulse: `MDUResult` is newly valid; drives HI/LO `HiloWrite`.
- `MDUResult`  out  2*WIDTH  {Hi,Lo}: product, or {remainder, quotient}.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, `Start`=1, `Cancel`=0: latch op, compute |SrcA| and |SrcB| (signed ops only), record result sign flags, clear the 64-bit accumulator, set count=0, go to CALC.
- CALC: one iteration per cycle. Count increments. When the cycle with count=31 completes, go to DONE.
  - Multiply: shift-add, LSB-first over the magnitude of SrcB.
  - Divide: restoring divide, MSB-first. Shift {rem,quot} left by 1, trial-subtract the divisor, set the quotient bit if the result is non-negative.
- Final edge into DONE: apply the sign fix and load `MDUResult`.
  - Product is negated (64-bit two's complement) if the signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- DONE: `Done`=1 for exactly one cycle, then go to IDLE unconditionally.
- Divide by zero, both signed and unsigned: quotient = all ones, remainder = SrcA unmodified. No exception is raised.
- Signed 0x80000000 / -1 gives quotient 0x80000000, remainder 0 (wraparound, no trap).
- `Start` in CALC or DONE is ignored; the new request is lost, and upstream must wait for `Busy`=0.
- `Cancel`=1 in any state: next state is IDLE, no `Done`, `MDUResult` unchanged. Cancel wins over a simultaneous `Start`.
- `MDUResult` holds its value until the next completed operation; it is never cleared by Start or Cancel.

## Timing
- Reset values: state IDLE, `Busy`=0, `Done`=0, `MDUResult`=0, count=0.
- Reset mid-operation aborts immediately (async); no `Done` is produced.
- `Start` sampled high at edge E0 → `Busy`=1 after E0. Iterations occur on edges E1..E32. `MDUResult` is loaded at E32. `Done`=1 and `Busy`=1 during the cycle E32–E33. After E33, `Busy`=0 and `Start` is accepted again.
- Latency from the Start edge to the Done cycle is 33 cycles for every op and every operand value; there is no early termination.
- `Done` is registered; the downstream HI/LO block sees it in the same cycle as the new `MDUResult`.

## Structure
- Package `mdu_pkg`:
  - op encodings `MDU_MULT`/`MDU_MULTU`/`MDU_DIV`/`MDU_DIVU`;
  - state typedef (IDLE/CALC/DONE);
  - `MDU_ITER` = 32.
- Sub-module `mdu_step`: combinational single-iteration datapath. It takes the accumulator, the operand magnitude and the op class, and returns the next accumulator. Both multiply and divide branches live there.
- Top level `mdu` holds the FSM, counter, sign capture, magnitude/negate logic and the result register.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `MDUResult`=0xFFFFFFFE_00000001, `Done` exactly 33 cycles after the Start edge, single pulse.
- MULT -3 × 5 → 0xFFFFFFFF_FFFFFFF1. MULT 0x80000000 × 0x80000000 → 0x40000000_00000000.
- DIV -7 / 2 → {0xFFFFFFFF, 0xFFFFFFFD}. DIVU 7 / 2 → {0x00000001, 0x00000003}.
- DIVU 100 / 0 → {0x00000064, 0xFFFFFFFF}. DIV 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}.
- Start pulsed again at cycle 5 of CALC → ignored; the first result completes normally. Cancel at cycle 10 → IDLE next cycle, no `Done`, previous `MDUResult` retained. Cancel + Start together in IDLE → stays IDLE.
- `rst` asserted at cycle 20 of a DIV → all outputs 0 immediately. A new DIVU 9 / 3 after release → {0, 3}.
